conv_a1_ofm_writer: RTL and testbench
=====================================

# conv_a1_ofm_writer

Output-side writer for the ConvA1 layer. It accepts the post-ReLU result stream from the ConvA1 datapath through a valid/ready handshake and buffers it in a small FIFO. It then writes each sample into the next layer's per-filter IFM memories, generating the one-hot bank select and the raster address. It is the write end of the next layer's IFM memories, which the ConvA2 datapath later reads.

## Interface
- DATA_WIDTH, 32, sample width (FP32)
- IFM_SIZE_NEXT, 28, output feature-map side length
- NUMBER_OF_FILTERS, 6, number of output maps, which is also the number of next-layer IFM banks
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), next-layer IFM address width (10 with defaults)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that begins a layer pass
- data_in  in  DATA_WIDTH  result sample (data_out_for_next of the datapath)
- data_in_valid  in  1  data_in holds a valid sample
- data_in_ready  out  1  writer can accept a sample this cycle
- mem_grant  in  1  next-layer IFM write port is available this cycle
- ifm_enable_write_next  out  NUMBER_OF_FILTERS  one-hot bank write enable
- ifm_address_write_next  out  ADDRESS_SIZE_NEXT_IFM  write address
- ifm_data_write_next  out  DATA_WIDTH  write data
- busy  out  1  a pass is in progress
- done  out  1  one-cycle pulse after the final write
- drop_error  out  1  sticky flag: a valid sample was presented while the writer was not running

## Operation
- FSM states:
  - IDLE: on start, go to RUN.
  - RUN: after the write of pixel IFM_SIZE_NEXT²−1 of filter NUMBER_OF_FILTERS−1, go to DONE.
  - DONE: unconditionally return to IDLE after one cycle.
- data_in_ready = (state==RUN) && !fifo_full. A sample is accepted when data_in_valid && data_in_ready.
- Write issue (combinational from FIFO head) happens when state==RUN && !fifo_empty && mem_grant:
  - ifm_enable_write_next = one-hot of filter_cnt
  - ifm_address_write_next = pix_cnt
  - ifm_data_write_next = FIFO head
  - The head is popped in the same cycle.
- When no write is issued, ifm_enable_write_next = 0. Address and data then hold their last values and are don't-care.
- Write order is filter-major with raster pixel order:
  - pix_cnt runs 0..IFM_SIZE_NEXT²−1 (0..783 with defaults), then wraps to 0 and filter_cnt increments.
  - filter_cnt runs 0..NUMBER_OF_FILTERS−1.
  - Total writes per pass are IFM_SIZE_NEXT²·NUMBER_OF_FILTERS (4704 with defaults).
- Simultaneous push and pop on a FIFO that is neither empty nor full: occupancy is unchanged and both occur.
- When the FIFO is full, a pop in the same cycle does not raise data_in_ready (ready is derived from registered occupancy).
- Counters clear on start and on the last write.
- start while in RUN or DONE is ignored.
- data_in_valid while state≠RUN sets drop_error. The sample is not stored. drop_error clears only on reset or start.
- busy = (state==RUN).
- done = (state==DONE).

## Timing
- Reset:
  - state=IDLE
  - FIFO emptied
  - counters=0
  - data_in_ready=0, ifm_enable_write_next=0, ifm_address_write_next=0, ifm_data_write_next=0
  - busy=0, done=0, drop_error=0
- Reset asserted mid-pass aborts the pass. Buffered samples are discarded and no done pulse is issued.
- start at cycle t: busy and data_in_ready rise at t+1.
- Latency: a sample accepted at cycle t appears on the write port at t+1 at the earliest, provided the FIFO was empty and mem_grant=1.
- Sustained throughput is 1 sample/cycle with mem_grant held high.
- When mem_grant is low, the FIFO absorbs up to FIFO_DEPTH samples, after which data_in_ready drops.
- The final write is at cycle w. At w+1: done=1, busy=0, data_in_ready=0. At w+2: done=0.

## Structure
- Shared package `conv_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE)
  - the default layer constants (IFM_SIZE_NEXT=28, NUMBER_OF_FILTERS=6)
  - the address-width function
- Sub-module `sync_fifo` (parameters DATA_WIDTH, FIFO_DEPTH) provides push, pop, head, full and empty. It is reusable by the other layer writers.
- The top level contains the FSM, the pix/filter counters, the one-hot decode and drop_error.

## Test plan
- Reset, then start, then 4704 back-to-back samples with value = index and mem_grant=1 -> each write lands at bank index/784, address index%784. The bank enable sequence is 000001…100000. done pulses exactly once, one cycle after the last write.
- mem_grant=0 for 10 cycles mid-stream -> exactly 4 samples accepted, then data_in_ready=0. After grant returns, writes resume in order with no loss or duplication.
- Pixel/filter wrap: after writing filter 0 address 783, the next write is enable=000010, address 0.
- data_in_valid=1 while IDLE -> drop_error=1 and no write occurs. A later start clears it.
- Reset asserted after 100 writes -> all outputs at reset values the next cycle. A new start restarts at bank 0, address 0.
- start pulsed again during RUN -> no counter reset. The pass completes with 4704 writes.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer writers: FSM encoding, default layer
// geometry and the IFM address-width helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IFM_SIZE_NEXT_DEF     = 28;
  localparam int NUMBER_OF_FILTERS_DEF = 6;

  // Width needed to address a side x side feature map (never narrower than 1).
  function automatic int ifm_addr_width(input int side);
    return (side * side > 1) ? $clog2(side * side) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; push is ignored
// when full and pop is ignored when empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: state registers use <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide what is valid, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/conv_a1_ofm_writer.sv
// ConvA1 result writer: buffers the post-ReLU stream and scatters it into the
// next layer's per-filter IFM banks in filter-major, raster pixel order.
module conv_a1_ofm_writer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE_NEXT_DEF,
  parameter int NUMBER_OF_FILTERS     = NUMBER_OF_FILTERS_DEF,
  parameter int FIFO_DEPTH            = 4,
  parameter int ADDRESS_SIZE_NEXT_IFM = ifm_addr_width(IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  input  logic                             mem_grant,
  output logic [NUMBER_OF_FILTERS-1:0]     ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic [DATA_WIDTH-1:0]            ifm_data_write_next,
  output logic                             busy,
  output logic                             done,
  output logic                             drop_error
);

  localparam int FILT_W = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] PIX_LAST =
    ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUMBER_OF_FILTERS - 1);

  state_t                           state;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] pix_cnt;
  logic [FILT_W-1:0]                filter_cnt;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [DATA_WIDTH-1:0]            fifo_head;
  logic                             accept;
  logic                             write_issue;
  logic                             last_write;
  logic                             start_accept;

  assign data_in_ready = (state == RUN) && !fifo_full;
  assign accept        = data_in_valid && data_in_ready;
  assign write_issue   = (state == RUN) && !fifo_empty && mem_grant;
  assign last_write    = write_issue && (pix_cnt == PIX_LAST) && (filter_cnt == FILT_LAST);
  assign start_accept  = start && (state == IDLE);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (data_in),
    .pop       (write_issue),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last_write) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel counter wraps into the filter counter; both restart on a new pass.
  always_ff @(posedge clk) begin
    if (reset || start_accept || last_write) begin
      pix_cnt    <= '0;
      filter_cnt <= '0;
    end else if (write_issue) begin
      if (pix_cnt == PIX_LAST) begin
        pix_cnt    <= '0;
        filter_cnt <= filter_cnt + FILT_W'(1);
      end else begin
        pix_cnt <= pix_cnt + ADDRESS_SIZE_NEXT_IFM'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      drop_error <= 1'b0;
    end else if (data_in_valid && (state != RUN)) begin
      drop_error <= 1'b1;
    end
  end

  // NOTE: default first so every path assigns the output and no latch is inferred.
  always_comb begin
    ifm_enable_write_next = '0;
    if (write_issue) ifm_enable_write_next = NUMBER_OF_FILTERS'(1) << filter_cnt;
  end

  assign ifm_address_write_next = pix_cnt;
  assign ifm_data_write_next    = fifo_empty ? '0 : fifo_head;
  assign busy                   = (state == RUN);
  assign done                   = (state == DONE);

endmodule

// File: tb/tb_conv_a1_ofm_writer.sv
// Scoreboard bench for conv_a1_ofm_writer: accepted samples queue their expected
// bank/address/data; a negedge monitor checks every write the DUT issues.
module tb_conv_a1_ofm_writer;

  localparam int DW    = 32;
  localparam int SIDE  = 28;
  localparam int NF    = 6;
  localparam int PIX   = SIDE * SIDE;
  localparam int TOTAL = PIX * NF;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic          mem_grant = 1'b1;
  logic [NF-1:0] ifm_enable_write_next;
  logic [AW-1:0] ifm_address_write_next;
  logic [DW-1:0] ifm_data_write_next;
  logic          busy;
  logic          done;
  logic          drop_error;

  conv_a1_ofm_writer dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .data_in                (data_in),
    .data_in_valid          (data_in_valid),
    .data_in_ready          (data_in_ready),
    .mem_grant              (mem_grant),
    .ifm_enable_write_next  (ifm_enable_write_next),
    .ifm_address_write_next (ifm_address_write_next),
    .ifm_data_write_next    (ifm_data_write_next),
    .busy                   (busy),
    .done                   (done),
    .drop_error             (drop_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   idx = 0;
  int   cyc = 0;
  int   pass_writes = 0;
  int   last_write_cycle = -1;
  int   done_cycle = -1;
  int   done_count = 0;
  bit   rand_grant = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference placement: sample k of a pass goes to bank k/PIX at raster address k%PIX.
  task automatic expect_sample(input logic [31:0] d);
    exp_t e;
    e.bank = idx / PIX;
    e.addr = idx % PIX;
    e.data = d;
    exp_q.push_back(e);
    idx++;
  endtask

  task automatic send(input logic [31:0] d);
    int waited = 0;
    data_in       = d;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!data_in_ready) begin
      $display("FAIL send_timeout: ready stuck low at sample %0d", idx);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
    end
    expect_sample(d);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic stall_test();
    int          acc = 0;
    logic [31:0] d;
    repeat (2) begin @(posedge clk); #1; end
    mem_grant = 1'b0;
    d = $urandom;
    for (int c = 0; c < 10; c++) begin
      data_in       = d;
      data_in_valid = 1'b1;
      @(negedge clk);
      if (data_in_ready) begin
        expect_sample(d);
        acc++;
        d = $urandom;
      end
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    check("stall_accepted", 64'(acc), 64'(4));
    check("stall_ready_low", 64'(data_in_ready), 64'(0));
    mem_grant = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int c = 0; c < 300 && done_count == base; c++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", 64'(done_count - base), 64'(1));
    check("done_timing", 64'(done_cycle), 64'(last_write_cycle + 1));
    check("all_written", 64'(pass_writes), 64'(TOTAL));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_grant) begin
      #1;
      mem_grant = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ifm_enable_write_next != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(ifm_enable_write_next), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("write_enable", 64'(ifm_enable_write_next), 64'(1) << mon_e.bank);
          check("write_address", 64'(ifm_address_write_next), 64'(mon_e.addr));
          check("write_data", 64'(ifm_data_write_next), 64'(mon_e.data));
          pass_writes++;
          if (pass_writes == TOTAL) last_write_cycle = cyc;
        end
      end
      if (done) begin
        done_count++;
        done_cycle = cyc;
        check("done_busy_low", 64'(busy), 64'(0));
        check("done_ready_low", 64'(data_in_ready), 64'(0));
      end
    end
  end

  initial begin
    bit stalled = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(data_in_ready), 64'(0));
    check("rst_enable", 64'(ifm_enable_write_next), 64'(0));
    check("rst_address", 64'(ifm_address_write_next), 64'(0));
    check("rst_data", 64'(ifm_data_write_next), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_drop", 64'(drop_error), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // A sample offered while idle is dropped and flagged.
    data_in       = 32'hDEAD_BEEF;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("drop_set", 64'(drop_error), 64'(1));
    check("drop_no_write", 64'(ifm_enable_write_next), 64'(0));
    check("drop_idle", 64'(busy), 64'(0));

    // Pass 1: back-to-back stream with a grant stall and a stray start.
    @(posedge clk); #1;
    pass_writes = 0;
    pulse_start();
    @(negedge clk);
    check("start_busy", 64'(busy), 64'(1));
    check("start_ready", 64'(data_in_ready), 64'(1));
    check("start_clears_drop", 64'(drop_error), 64'(0));
    @(posedge clk); #1;
    idx = 0;
    while (idx < TOTAL) begin
      if (idx == 2000 && !stalled) begin
        stalled = 1'b1;
        stall_test();
      end else begin
        if (idx == 50) start = 1'b1;
        send($urandom);
        start = 1'b0;
      end
    end
    wait_done(0);

    // Pass 2: aborted by reset after 100 writes.
    pass_writes = 0;
    pulse_start();
    idx = 0;
    while (idx < 100) send($urandom);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("abort_writes", 64'(pass_writes), 64'(100));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(data_in_ready), 64'(0));
    check("abort_enable", 64'(ifm_enable_write_next), 64'(0));
    check("abort_address", 64'(ifm_address_write_next), 64'(0));
    check("abort_data", 64'(ifm_data_write_next), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_no_done", 64'(done_count), 64'(1));
    exp_q.delete();

    // Pass 3: full pass from bank 0 with random grant.
    @(posedge clk); #1;
    pass_writes = 0;
    pulse_start();
    rand_grant = 1'b1;
    idx = 0;
    while (idx < TOTAL) send($urandom);
    wait_done(1);
    rand_grant = 1'b0;
    #2;
    mem_grant = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
